// File: rtl/giraffe_rx_decoder_if.sv
// Byte-in / sample-out handshake bundle for the giraffe RX decoder.
interface giraffe_rx_decoder_if #(
    parameter int N_bit  = 6,
    parameter int N_data = 8
);
    logic              rx_valid;
    logic [N_data-1:0] rx_data;
    logic              out_ready;
    logic              out_valid;
    logic [N_bit-1:0]  out_data;
    logic              out_main;

    // Byte source / sample sink side
    modport master (
        output rx_valid, rx_data, out_ready,
        input  out_valid, out_data, out_main
    );

    // Decoder side
    modport slave (
        input  rx_valid, rx_data, out_ready,
        output out_valid, out_data, out_main
    );
endinterface

// File: rtl/giraffe_rx_decoder.sv
// Giraffe RX decoder: tag-based framing lock on received UART bytes, main/sub
// ADC sample FIFO with overflow detection, and saturating statistics counters.
module giraffe_rx_decoder #(
    parameter int N_bit      = 6,
    parameter int N_data     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          clr_cnt,
    giraffe_rx_decoder_if.slave           bus,
    output logic                          locked,
    output logic                          err_tag,
    output logic                          err_ovf,
    output logic [CNT_W-1:0]              main_cnt,
    output logic [CNT_W-1:0]              sub_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int TAG_W = N_data - N_bit;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {SEARCH, LOCKED} state_t;

    // Tag decode, only meaningful while rx_valid is high
    logic [TAG_W-1:0] tag;
    logic             tag_main, tag_sub, tag_bad;

    assign tag      = bus.rx_data[N_data-1:N_bit];
    assign tag_main = &tag;
    assign tag_sub  = ~|tag;
    assign tag_bad  = bus.rx_valid & ~(tag_main | tag_sub);

    // Framing FSM
    state_t     state_q, state_d;
    logic [1:0] run_q, run_d;
    logic       push_req;

    // State and run-counter register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= SEARCH;
            run_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next state: two good tags in a row lock; any bad tag drops back to search
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        push_req = 1'b0;
        if (bus.rx_valid) begin
            if (tag_bad) begin
                state_d = SEARCH;
                run_d   = 2'd0;
            end else if (state_q == SEARCH) begin
                if (run_q == 2'd1) begin
                    state_d = LOCKED;
                    run_d   = 2'd0;
                end else begin
                    run_d = run_q + 2'd1;
                end
            end else begin
                push_req = 1'b1;
            end
        end
    end

    assign locked = (state_q == LOCKED);

    // Sample FIFO: entry = {main flag, ADC code}
    logic [N_bit:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic            full, pop, push, ovf;

    assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = (cnt_q != '0) & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push = push_req & (~full | pop);
    assign ovf  = push_req & full & ~pop;

    // Occupancy next value
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written, output is gated when empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {tag_main, bus.rx_data[N_bit-1:0]};
    end

    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_q[rd_q][N_bit-1:0] : '0;
    assign bus.out_main  = bus.out_valid ? mem_q[rd_q][N_bit]     : 1'b0;
    assign fifo_level    = cnt_q;

    // Error pulses, one cycle after the offending byte's edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_tag <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_tag <= tag_bad;
            err_ovf <= ovf;
        end
    end

    // Saturating statistics counters; clear wins over increment
    logic [CNT_W-1:0] main_q, sub_q, err_q;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            main_q <= '0;
            sub_q  <= '0;
            err_q  <= '0;
        end else if (clr_cnt) begin
            main_q <= '0;
            sub_q  <= '0;
            err_q  <= '0;
        end else begin
            if (push && tag_main && main_q != CNT_MAX) main_q <= main_q + 1'b1;
            if (push && tag_sub  && sub_q  != CNT_MAX) sub_q  <= sub_q + 1'b1;
            if ((tag_bad || ovf) && err_q  != CNT_MAX) err_q  <= err_q + 1'b1;
        end
    end

    assign main_cnt = main_q;
    assign sub_cnt  = sub_q;
    assign err_cnt  = err_q;
endmodule
